// File: rtl/single_port_ram.sv
// 32 x 8 synchronous single-port scratch RAM with a registered read port.
// Reads are read-before-write when both enables hit the same address on one edge.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage must clear on reset, so it is built from resettable flops
  // rather than a RAM macro; a macro cannot clear every word asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enb) begin
      mem[address] <= data_in;
    end
  end

  // NOTE: non-blocking updates mean this read sees mem before the same-edge
  // write lands, which is exactly the read-before-write behaviour we want.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (read_enb) begin
      data_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_single_port_ram.sv
// Scoreboard bench for single_port_ram: the driver queues expected read data,
// and a monitor compares data_out on the negedge after each sampled read.
module tb_single_port_ram;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       write_enb;
  logic       read_enb;
  logic [4:0] address;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  logic       rd_fire = 1'b0;

  single_port_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .DEPTH     (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .write_enb(write_enb),
    .read_enb (read_enb),
    .address  (address),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read sampled at a posedge presents its data by the following negedge.
  always @(posedge clk) rd_fire <= read_enb && !reset;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got %02h with empty scoreboard at %0t", data_out, $time);
      end else begin
        check("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    write_enb = 1'b0;
    read_enb  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    address   = a;
    data_in   = d;
    write_enb = 1'b1;
    read_enb  = 1'b0;
    @(negedge clk);
    write_enb = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    address   = a;
    write_enb = 1'b0;
    read_enb  = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    read_enb  = 1'b0;
  endtask

  task automatic rdwr(input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp);
    address   = a;
    data_in   = d;
    write_enb = 1'b1;
    read_enb  = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    write_enb = 1'b0;
    read_enb  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = '0;
    write_enb = 1'b0;
    read_enb  = 1'b0;
    address   = '0;
    repeat (2) @(negedge clk);
    check("reset_initial", data_out, 8'h00);
    reset = 1'b0;

    // Load non-zero content so the reset clear is observable.
    wr(5'd15, 8'h77);
    wr(5'd31, 8'h77);
    rd(5'd15, 8'h77);
    wr(5'd0, 8'hA5);
    rd(5'd0, 8'hA5);
    idle();

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    @(posedge clk);
    #2;
    check("pre_reset_hold", data_out, 8'hA5);
    reset = 1'b1;
    #1;
    check("reset_async", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd(5'd0,  8'h00);
    rd(5'd15, 8'h00);
    rd(5'd31, 8'h00);

    // Basic write then read back.
    wr(5'd5, 8'h3C);
    rd(5'd5, 8'h3C);

    // Full sweep with pattern addr ^ 8'h55 (addr 0 -> 55, addr 31 -> 4A).
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i) ^ 8'h55);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'(i) ^ 8'h55);
    rd(5'd0,  8'h55);
    rd(5'd31, 8'h4A);

    // Hold: data_out keeps its value while read_enb is low and address moves.
    wr(5'd5, 8'h3C);
    rd(5'd5, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      address = 5'(k * 7 + 1);
      idle();
      check("hold", data_out, 8'h3C);
    end

    // Same-edge read and write to one address returns the old word.
    wr(5'd7, 8'h11);
    rdwr(5'd7, 8'h22, 8'h11);
    rd(5'd7, 8'h22);

    // Write and read presented during reset are discarded.
    address   = 5'd9;
    data_in   = 8'hFF;
    write_enb = 1'b1;
    read_enb  = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check("reset_midop_out", data_out, 8'h00);
    write_enb = 1'b0;
    read_enb  = 1'b0;
    reset     = 1'b0;
    rd(5'd9, 8'h00);
    rd(5'd7, 8'h00);
    wr(5'd9, 8'h66);
    rd(5'd9, 8'h66);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) idle();
    idle();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d reads never observed, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/single_port_ram.md
Name: single_port_ram

Overview:
- Synchronous single-port RAM, 32 words x 8 bits, with one shared address bus and separate write and read enables.
- Registered read data output.
- Serves as a small scratch memory: the driver side supplies write_enb, read_enb, data_in and address; the monitor samples data_out on the following clock edge.

Parameters:
- DATA_WIDTH, 8, word width in bits (data_in, data_out, memory words).
- ADDR_WIDTH, 5, address width in bits.
- DEPTH, 32 (2**ADDR_WIDTH), number of words.

Ports:
- clk  input  1  system clock; all non-reset activity occurs on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- write_enb  input  1  write enable; 1 = write data_in to mem[address] at the clock edge.
- read_enb  input  1  read enable; 1 = load mem[address] into data_out at the clock edge.
- address  input  ADDR_WIDTH  word address shared by read and write.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset:
  - Reset assertion immediately (no clock needed) forces data_out = 0.
  - Reset clears all DEPTH memory words to 0.
  - Both hold while reset = 1.
  - Writes and reads are ignored while reset = 1.
- Reset release:
  - The first rising clk edge with reset = 0 performs normal operation.
  - Memory reads 0 until written.
- Write:
  - At posedge clk with write_enb = 1: mem[address] <= data_in.
  - Written data is visible to a read issued on the next edge or later.
- Read:
  - At posedge clk with read_enb = 1: data_out <= mem[address].
  - Latency is 1 clock: the value is valid after the edge where read_enb was sampled.
- No read: with read_enb = 0, data_out holds its previous value (no return to 0).
- Simultaneous write and read, same edge:
  - Both operations execute.
  - Same address: read-before-write. data_out gets the old mem content; the new data is stored and returned by the next read.
  - Different addresses: independent.
- Idle: write_enb = 0 and read_enb = 0 leaves memory and data_out unchanged.
- Address range:
  - All 2**ADDR_WIDTH addresses are valid (0..31).
  - No wrap logic is needed; address 31 is the last word.
- X handling:
  - X/Z on address while an enable is active must not corrupt other words.
  - Implementation must not write when write_enb is not 1.
- Reset mid-operation: an enable asserted in the same cycle as reset is discarded; no partial write.
- No handshake, backpressure, or status outputs; every enabled operation completes in one cycle.

Test Plan:
- Reset check: assert reset mid-cycle with data_out = 8'hA5 -> data_out = 8'h00 immediately, without waiting for a clk edge. After release, read addresses 0, 15 and 31 -> each returns 8'h00.
- Write/read back: write 8'h3C to addr 5, then read addr 5 on the next edge -> data_out = 8'h3C one cycle after the read edge.
- Full sweep: write data = addr ^ 8'h55 to addresses 0..31, then read 0..31 -> each returns the matching pattern, including addr 0 = 8'h55 and addr 31 = 8'h4A.
- Hold: read addr 5 (8'h3C), then 3 cycles with read_enb = 0 and address changing -> data_out stays 8'h3C.
- Simultaneous read/write: mem[7] = 8'h11; in one cycle write 8'h22 with read, addr 7 -> data_out = 8'h11; next read of addr 7 -> 8'h22.
- Reset mid-operation: assert reset on the same cycle as a write of 8'hFF to addr 9 -> after release, reading addr 9 returns 8'h00.
